// File: rtl/alu_result_stage.sv
// Result stage behind the ALU function decoder: muxes the one-hot unit result into
// a small FWFT FIFO with a valid/ready output and sticky protocol-error flags.
module alu_result_stage #(
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ALU_EN,
  input  logic                        Arith_Enable,
  input  logic                        Logic_Enable,
  input  logic                        CMP_Enable,
  input  logic                        Shift_Enable,
  input  logic [OUT_WIDTH-1:0]        Arith_OUT,
  input  logic                        Arith_Carry,
  input  logic [OUT_WIDTH-1:0]        Logic_OUT,
  input  logic [OUT_WIDTH-1:0]        CMP_OUT,
  input  logic [OUT_WIDTH-1:0]        Shift_OUT,
  output logic                        IN_READY,
  output logic [OUT_WIDTH-1:0]        ALU_OUT,
  output logic                        ALU_CARRY,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
  output logic                        ERR_ONEHOT,
  output logic                        ERR_OVF,
  input  logic                        ERR_CLR
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Each entry is {carry, data}
  logic [OUT_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [OUT_WIDTH:0] r_last;
  logic               r_err_onehot;
  logic               r_err_ovf;

  logic [OUT_WIDTH-1:0] w_sel_data;
  logic                 w_sel_carry;
  logic                 w_onehot;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [OUT_WIDTH:0]   w_head;

  // AND-OR mux is only meaningful when the enables are one-hot, which gates the push
  assign w_sel_data  = ({OUT_WIDTH{Arith_Enable}} & Arith_OUT)
                     | ({OUT_WIDTH{Logic_Enable}} & Logic_OUT)
                     | ({OUT_WIDTH{CMP_Enable}}   & CMP_OUT)
                     | ({OUT_WIDTH{Shift_Enable}} & Shift_OUT);
  assign w_sel_carry = Arith_Enable & Arith_Carry;

  assign w_onehot = $onehot({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable});
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_push   = ALU_EN & w_onehot & ~w_full;
  assign w_pop    = ~w_empty & OUT_READY;
  assign w_head   = r_mem[r_rd_ptr];

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_sel_carry, w_sel_data};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= w_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Error set has priority over a coincident clear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_err_onehot <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      if (ALU_EN && !w_onehot) begin
        r_err_onehot <= 1'b1;
      end else if (ERR_CLR) begin
        r_err_onehot <= 1'b0;
      end
      if (ALU_EN && w_full) begin
        r_err_ovf <= 1'b1;
      end else if (ERR_CLR) begin
        r_err_ovf <= 1'b0;
      end
    end
  end

  // While empty the output holds the most recently popped entry
  assign ALU_OUT    = w_empty ? r_last[OUT_WIDTH-1:0] : w_head[OUT_WIDTH-1:0];
  assign ALU_CARRY  = w_empty ? r_last[OUT_WIDTH]     : w_head[OUT_WIDTH];
  assign OUT_VALID  = ~w_empty;
  assign IN_READY   = ~w_full;
  assign FIFO_COUNT = r_count;
  assign ERR_ONEHOT = r_err_onehot;
  assign ERR_OVF    = r_err_ovf;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected entries are queued when a push is
// driven and compared against the FWFT head when each pop is driven.
module tb_alu_result_stage;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alu_en, ar_en, lo_en, cm_en, sh_en;
  logic [W-1:0] ar_out, lo_out, cm_out, sh_out;
  logic         ar_carry;
  logic         in_ready;
  logic [W-1:0] alu_out;
  logic         alu_carry;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   fifo_count;
  logic         err_onehot, err_ovf, err_clr;

  int checks = 0;
  int errors = 0;

  logic [W:0]   q[$];
  logic [W-1:0] exp_data;
  logic         exp_carry;
  logic         m_err_onehot = 1'b0;
  logic         m_err_ovf    = 1'b0;

  always #5 clk = ~clk;

  alu_result_stage #(.OUT_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst_n), .ALU_EN(alu_en),
    .Arith_Enable(ar_en), .Logic_Enable(lo_en), .CMP_Enable(cm_en), .Shift_Enable(sh_en),
    .Arith_OUT(ar_out), .Arith_Carry(ar_carry), .Logic_OUT(lo_out), .CMP_OUT(cm_out),
    .Shift_OUT(sh_out), .IN_READY(in_ready), .ALU_OUT(alu_out), .ALU_CARRY(alu_carry),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .FIFO_COUNT(fifo_count),
    .ERR_ONEHOT(err_onehot), .ERR_OVF(err_ovf), .ERR_CLR(err_clr)
  );

  // en = {arith, logic, cmp, shift}; unselected buses carry noise
  task automatic drive_op(input logic [3:0] en, input logic [W-1:0] d, input logic c);
    alu_en   = 1'b1;
    {ar_en, lo_en, cm_en, sh_en} = en;
    ar_out   = en[3] ? d : W'($urandom);
    lo_out   = en[2] ? d : W'($urandom);
    cm_out   = en[1] ? d : W'($urandom);
    sh_out   = en[0] ? d : W'($urandom);
    ar_carry = c;
    exp_data  = d;
    exp_carry = en[3] & c;
  endtask

  task automatic idle_inputs();
    alu_en = 1'b0;
    {ar_en, lo_en, cm_en, sh_en} = 4'b0000;
    err_clr = 1'b0;
  endtask

  // Model update for the coming rising edge, then wait for the next falling edge
  task automatic advance();
    logic oh, acc, pp, bad, ovf;
    oh  = $onehot({ar_en, lo_en, cm_en, sh_en});
    acc = alu_en && oh && (q.size() < DEPTH);
    pp  = out_ready && (q.size() != 0);
    bad = alu_en && !oh;
    ovf = alu_en && (q.size() == DEPTH);
    @(negedge clk);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back({exp_carry, exp_data});
    m_err_onehot = bad ? 1'b1 : (err_clr ? 1'b0 : m_err_onehot);
    m_err_ovf    = ovf ? 1'b1 : (err_clr ? 1'b0 : m_err_ovf);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    ar_out = '0; lo_out = '0; cm_out = '0; sh_out = '0; ar_carry = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status got valid=%b count=%0d in_ready=%b expected 0 0 1", out_valid, fifo_count, in_ready);
    end
    checks++;
    if (alu_out !== 16'h0000 || alu_carry !== 1'b0 || err_onehot !== 1'b0 || err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got out=%h carry=%b eoh=%b eovf=%b expected 0000 0 0 0", alu_out, alu_carry, err_onehot, err_ovf);
    end
    $display("reset: valid=%b count=%0d out=%h", out_valid, fifo_count, alu_out);
  endtask

  task automatic test_arith();
    drive_op(4'b1000, 16'h00FF, 1'b1);
    advance();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 16'h00FF || alu_carry !== 1'b1 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL arith_push got valid=%b out=%h carry=%b count=%0d expected 1 00ff 1 1", out_valid, alu_out, alu_carry, fifo_count);
    end
    $display("arith push: out=%h carry=%b count=%0d", alu_out, alu_carry, fifo_count);
    out_ready = 1'b1;
    checks++;
    if ({alu_carry, alu_out} !== q[0]) begin
      errors++;
      $display("FAIL arith_pop got %h expected %h", {alu_carry, alu_out}, q[0]);
    end
    advance();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || alu_out !== 16'h00FF || alu_carry !== 1'b1) begin
      errors++;
      $display("FAIL arith_hold got valid=%b out=%h carry=%b expected 0 00ff 1", out_valid, alu_out, alu_carry);
    end
  endtask

  task automatic test_order();
    drive_op(4'b0100, 16'h1111, 1'b1); advance();
    drive_op(4'b0010, 16'h0001, 1'b1); advance();
    drive_op(4'b0001, 16'h8000, 1'b1); advance();
    idle_inputs();
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL order_count got %0d expected 3", fifo_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || {alu_carry, alu_out} !== q[0] || alu_carry !== 1'b0) begin
        errors++;
        $display("FAIL order_pop%0d got valid=%b %h expected 1 %h", i, out_valid, {alu_carry, alu_out}, q[0]);
      end
      $display("order pop %0d: out=%h carry=%b", i, alu_out, alu_carry);
      advance();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL order_empty got valid=%b count=%0d expected 0 0", out_valid, fifo_count);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_op(4'b1000, 16'hA000 + 16'(i), 1'b0);
      advance();
      if (i == 3) begin
        checks++;
        if (in_ready !== 1'b0 || fifo_count !== 3'd4 || err_ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full got in_ready=%b count=%0d eovf=%b expected 0 4 0", in_ready, fifo_count, err_ovf);
        end
      end
    end
    idle_inputs();
    checks++;
    if (err_ovf !== m_err_ovf || err_ovf !== 1'b1 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_flag got eovf=%b count=%0d expected 1 4", err_ovf, fifo_count);
    end
    $display("overflow: eovf=%b count=%0d", err_ovf, fifo_count);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (alu_out !== 16'hA000 + 16'(i) || {alu_carry, alu_out} !== q[0]) begin
        errors++;
        $display("FAIL ovf_pop%0d got %h expected %h", i, alu_out, 16'hA000 + 16'(i));
      end
      advance();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL ovf_drain got valid=%b count=%0d expected 0 0", out_valid, fifo_count);
    end
    err_clr = 1'b1;
    advance();
    idle_inputs();
    checks++;
    if (err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b expected 0", err_ovf);
    end
  endtask

  task automatic test_onehot_err();
    drive_op(4'b1001, 16'h5555, 1'b0); advance();
    checks++;
    if (err_onehot !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL onehot_double got eoh=%b count=%0d expected 1 0", err_onehot, fifo_count);
    end
    drive_op(4'b0000, 16'h6666, 1'b0); advance();
    checks++;
    if (err_onehot !== m_err_onehot || err_onehot !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL onehot_none got eoh=%b count=%0d expected 1 0", err_onehot, fifo_count);
    end
    idle_inputs();
    err_clr = 1'b1; advance();
    err_clr = 1'b0;
    checks++;
    if (err_onehot !== 1'b0) begin
      errors++;
      $display("FAIL onehot_clear got %b expected 0", err_onehot);
    end
    drive_op(4'b0110, 16'h7777, 1'b0);
    err_clr = 1'b1; advance();
    idle_inputs();
    checks++;
    if (err_onehot !== 1'b1) begin
      errors++;
      $display("FAIL onehot_set_wins got %b expected 1", err_onehot);
    end
    err_clr = 1'b1; advance();
    idle_inputs();
    drive_op(4'b1100, 16'h1234, 1'b0);
    alu_en = 1'b0; advance();
    drive_op(4'b0100, 16'h4321, 1'b0);
    alu_en = 1'b0; advance();
    idle_inputs();
    checks++;
    if (err_onehot !== 1'b0 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_en_low got eoh=%b count=%0d valid=%b expected 0 0 0", err_onehot, fifo_count, out_valid);
    end
    $display("onehot errors: eoh=%b count=%0d", err_onehot, fifo_count);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_op(4'b0100, 16'h00A0, 1'b0); advance();
    drive_op(4'b0010, 16'h00A1, 1'b0); advance();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_op(4'(1 << (i % 4)), 16'h0010 + 16'(i), 1'b1);
      checks++;
      if ({alu_carry, alu_out} !== q[0] || fifo_count !== 3'd2) begin
        errors++;
        $display("FAIL b2b_%0d got %h count=%0d expected %h count=2", i, {alu_carry, alu_out}, fifo_count, q[0]);
      end
      $display("b2b %0d: out=%h count=%0d", i, alu_out, fifo_count);
      advance();
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({alu_carry, alu_out} !== q[0] || alu_out !== 16'h0018 + 16'(i)) begin
        errors++;
        $display("FAIL b2b_drain%0d got %h expected %h", i, alu_out, 16'h0018 + 16'(i));
      end
      advance();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_empty got valid=%b count=%0d expected 0 0", out_valid, fifo_count);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive_op(4'b1000, 16'hBEEF, 1'b1); advance();
    drive_op(4'b0100, 16'hCAFE, 1'b0); advance();
    drive_op(4'b0010, 16'hD00D, 1'b0); advance();
    drive_op(4'b0000, 16'h0000, 1'b0); advance();
    idle_inputs();
    checks++;
    if (fifo_count !== 3'd3 || err_onehot !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got count=%0d eoh=%b expected 3 1", fifo_count, err_onehot);
    end
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_err_onehot = 1'b0;
    m_err_ovf    = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || err_onehot !== 1'b0 || err_ovf !== 1'b0 || alu_out !== 16'h0000) begin
      errors++;
      $display("FAIL arst_now got valid=%b count=%0d eoh=%b eovf=%b out=%h expected 0 0 0 0 0000",
               out_valid, fifo_count, err_onehot, err_ovf, alu_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_op(4'b0001, 16'h0F0F, 1'b1); advance();
    idle_inputs();
    checks++;
    if (fifo_count !== 3'd1 || {alu_carry, alu_out} !== q[0] || alu_out !== 16'h0F0F) begin
      errors++;
      $display("FAIL arst_first got count=%0d out=%h expected 1 0f0f", fifo_count, alu_out);
    end
    out_ready = 1'b1; advance();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL arst_alone got valid=%b count=%0d expected 0 0", out_valid, fifo_count);
    end
    $display("async reset: first push out=%h alone", alu_out);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_order();
    test_overflow();
    test_onehot_err();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Downstream stage of the ALU function decoder. It consumes the four one-hot unit enables (Arith/Logic/CMP/Shift) together with each unit's result bus. It selects and registers the active unit's result into a small first-word-fall-through FIFO, then presents it to the consumer (register file write-back / UART TX path) through a valid/ready handshake. It also flags protocol errors: non-one-hot enables and overflow.

Parameters:
OUT_WIDTH, 16, width of every unit result and of ALU_OUT
FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
ALU_EN  input  1  qualifies enables/results as a real operation this cycle
Arith_Enable  input  1  decoder output, arithmetic unit selected
Logic_Enable  input  1  decoder output, logic unit selected
CMP_Enable  input  1  decoder output, compare unit selected
Shift_Enable  input  1  decoder output, shift unit selected
Arith_OUT  input  OUT_WIDTH  arithmetic unit result
Arith_Carry  input  1  arithmetic carry/borrow
Logic_OUT  input  OUT_WIDTH  logic unit result
CMP_OUT  input  OUT_WIDTH  compare unit result
Shift_OUT  input  OUT_WIDTH  shift unit result
IN_READY  output  1  FIFO can accept a result (count < FIFO_DEPTH)
ALU_OUT  output  OUT_WIDTH  head-of-FIFO result
ALU_CARRY  output  1  head-of-FIFO carry (0 unless entry came from arithmetic)
OUT_VALID  output  1  head entry valid
OUT_READY  input  1  consumer accepts head entry
FIFO_COUNT  output  log2(FIFO_DEPTH)+1  current occupancy
ERR_ONEHOT  output  1  sticky: ALU_EN with zero or multiple enables
ERR_OVF  output  1  sticky: ALU_EN while FIFO full
ERR_CLR  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (RST low, async): FIFO empty, pointers 0, FIFO_COUNT=0, OUT_VALID=0, ALU_OUT=0, ALU_CARRY=0, IN_READY=1, ERR_ONEHOT=0, ERR_OVF=0. Reset asserted mid-operation discards all stored entries.
- Select: when exactly one enable is high, data = that unit's OUT. Carry = Arith_Carry for arithmetic, else 0.
- Push: ALU_EN=1, enables one-hot, IN_READY=1 -> {carry,data} written at write pointer on that edge.
- Enables ignored entirely when ALU_EN=0 (no push, no error).
- Non-one-hot (zero or >=2 enables) with ALU_EN=1: no push, ERR_ONEHOT set next edge.
- Full: ALU_EN=1 with count==FIFO_DEPTH -> result dropped, ERR_OVF set. IN_READY is purely count-based: a same-cycle pop does not admit a push when full.
- Pop: OUT_VALID && OUT_READY on edge -> read pointer advances. OUT_READY while empty has no effect.
- Output is FWFT: ALU_OUT/ALU_CARRY are the head entry, combinationally from storage, and are held stable while OUT_VALID=1 and OUT_READY=0. When empty, ALU_OUT/ALU_CARRY hold the last popped value (0 after reset). OUT_VALID = (count != 0).
- Latency: a push on edge N gives OUT_VALID=1 after edge N when the FIFO was empty (one cycle, registered).
- Simultaneous push and pop (not full): count unchanged; order preserved.
- Pointers wrap modulo FIFO_DEPTH. Count saturates only logically; it never exceeds FIFO_DEPTH or goes below 0.
- ERR_CLR: clears both flags. If a new error event occurs in the same cycle, set wins.

Test Plan:
- Reset then push Arith_Enable, Arith_OUT=0x00FF, carry=1 -> next cycle OUT_VALID=1, ALU_OUT=0x00FF, ALU_CARRY=1, FIFO_COUNT=1.
- Push Logic 0x1111, CMP 0x0001, Shift 0x8000 back-to-back, OUT_READY=0 -> FIFO_COUNT=3. Then OUT_READY=1 -> pops in order 0x1111, 0x0001, 0x8000 with ALU_CARRY=0 each; OUT_VALID drops after the third pop.
- 5 consecutive valid pushes, OUT_READY=0, depth 4 -> IN_READY=0 after the 4th; 5th dropped; ERR_OVF=1. Pop 4 entries and confirm the first 4 values only.
- ALU_EN=1 with Arith+Shift both high, then again with no enables -> no push, FIFO_COUNT unchanged, ERR_ONEHOT=1. ERR_CLR=1 -> flag 0. ERR_CLR coincident with a new bad enable -> flag stays 1.
- Count=2, continuous push+pop for 10 cycles with incrementing data 0x0010..0x0019 -> FIFO_COUNT stays 2 and output order matches input through pointer wrap.
- Assert RST low with count=3 mid-stream -> immediately OUT_VALID=0, FIFO_COUNT=0, flags 0. After release, a first push appears alone.
